// File: rtl/clk_sel_ctrl.sv
// clk_sel_ctrl: control stage upstream of the glitch-free two-source clock mux.
//
// Accepts source-select requests over valid/ready, checks the target source is
// healthy (synchronized ok flags), drives the mux select, waits a settle interval,
// then enforces a minimum dwell time before the next switch.
//
// Ports:
//   clk          control clock, always running
//   rst          asynchronous reset, active-high
//   req_valid    select request valid
//   req_sel      requested source: 1 = clka, 0 = clkb
//   req_ready    request accepted when req_valid && req_ready
//   ok_a, ok_b   asynchronous source health flags
//   en           registered mux select: 1 = clka, 0 = clkb
//   cur_sel      committed source, updates at switch_done
//   busy         high while settling or dwelling
//   switch_done  one-cycle pulse at end of settle, or on a same-source accept
//   err_reject   one-cycle pulse when a request is refused
//   switch_cnt   number of real switches, saturating at 255
//   fail_event   (only with CLK_SEL_FAILOVER_EN) pulse when an autonomous
//                failover switch starts
//
// Optional feature macro: CLK_SEL_FAILOVER_EN

module clk_sel_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned DWELL_CYCLES  = 64,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic       req_sel,
    output logic       req_ready,
    input  logic       ok_a,
    input  logic       ok_b,
    output logic       en,
    output logic       cur_sel,
    output logic       busy,
    output logic       switch_done,
    output logic       err_reject,
    output logic [7:0] switch_cnt
`ifdef CLK_SEL_FAILOVER_EN
    ,
    output logic       fail_event
`endif
);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LOAD  = (DWELL_CYCLES == 0) ? '0 :
                                               CNT_W'(DWELL_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StSettle, StDwell} state_e;

    state_e                 r_state;
    state_e                 w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;

    logic [SYNC_STAGES-1:0] r_sync_a;
    logic [SYNC_STAGES-1:0] r_sync_b;
    logic                   w_ok_a_s;
    logic                   w_ok_b_s;

    logic                   r_en;
    logic                   r_cur_sel;
    logic                   r_switch_done;
    logic                   r_err_reject;
    logic [7:0]             r_switch_cnt;

    logic                   w_failover;
    logic                   w_accept;
    logic                   w_target_ok;
    logic                   w_start;
    logic                   w_new_en;
    logic                   w_settle_end;
    logic                   w_done_nxt;
    logic                   w_rej_nxt;

    // Health flags are asynchronous; every decision uses the synchronized copies.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync_a <= '0;
            r_sync_b <= '0;
        end else begin
            r_sync_a <= {r_sync_a[SYNC_STAGES-2:0], ok_a};
            r_sync_b <= {r_sync_b[SYNC_STAGES-2:0], ok_b};
        end
    end

    assign w_ok_a_s = r_sync_a[SYNC_STAGES-1];
    assign w_ok_b_s = r_sync_b[SYNC_STAGES-1];

`ifdef CLK_SEL_FAILOVER_EN
    // Committed source unhealthy while the other one is healthy.
    assign w_failover = (r_state == StIdle) &&
                        (r_cur_sel ? (!w_ok_a_s && w_ok_b_s) : (!w_ok_b_s && w_ok_a_s));
`else
    assign w_failover = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            StIdle: begin
                if (w_start) begin
                    w_state_nxt = StSettle;
                    w_cnt_nxt   = SETTLE_LOAD;
                end
            end
            StSettle: begin
                if (r_cnt == '0) begin
                    w_state_nxt = (DWELL_CYCLES == 0) ? StIdle : StDwell;
                    w_cnt_nxt   = DWELL_LOAD;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            StDwell: begin
                if (r_cnt == '0) begin
                    w_state_nxt = StIdle;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = StIdle;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs and decode of the registered pulse/select updates.
    always_comb begin
        // Failover wins over a coincident request; the request stays pending.
        req_ready    = (r_state == StIdle) && !rst && !w_failover;
        busy         = (r_state != StIdle);
        w_accept     = req_valid && req_ready;
        w_target_ok  = req_sel ? w_ok_a_s : w_ok_b_s;
        w_start      = w_failover || (w_accept && (req_sel != r_cur_sel) && w_target_ok);
        w_new_en     = w_failover ? ~r_cur_sel : req_sel;
        w_settle_end = (r_state == StSettle) && (r_cnt == '0);
        w_done_nxt   = w_settle_end || (w_accept && (req_sel == r_cur_sel));
        w_rej_nxt    = w_accept && (req_sel != r_cur_sel) && !w_target_ok;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_en          <= 1'b0;
            r_cur_sel     <= 1'b0;
            r_switch_done <= 1'b0;
            r_err_reject  <= 1'b0;
            r_switch_cnt  <= 8'd0;
        end else begin
            r_switch_done <= w_done_nxt;
            r_err_reject  <= w_rej_nxt;
            if (w_start) begin
                r_en <= w_new_en;
            end
            if (w_settle_end) begin
                r_cur_sel <= r_en;
                if (r_switch_cnt != 8'hFF) begin
                    r_switch_cnt <= r_switch_cnt + 8'd1;
                end
            end
        end
    end

`ifdef CLK_SEL_FAILOVER_EN
    logic r_fail_event;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fail_event <= 1'b0;
        end else begin
            r_fail_event <= w_failover;
        end
    end

    assign fail_event = r_fail_event;
`endif

    assign en          = r_en;
    assign cur_sel     = r_cur_sel;
    assign switch_done = r_switch_done;
    assign err_reject  = r_err_reject;
    assign switch_cnt  = r_switch_cnt;

endmodule

// File: tb/tb_clk_sel_ctrl.sv
// Self-checking bench for clk_sel_ctrl (default build, failover disabled).
// A timestamp-based model predicts outputs; a negedge process compares them every
// cycle, and directed steps add literal expectations.

module tb_clk_sel_ctrl;

    localparam int S  = 16;
    localparam int D  = 64;
    localparam int SS = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_sel = 1'b0;
    logic       ok_a = 1'b1;
    logic       ok_b = 1'b1;
    logic       req_ready;
    logic       en;
    logic       cur_sel;
    logic       busy;
    logic       switch_done;
    logic       err_reject;
    logic [7:0] switch_cnt;

    int checks = 0;
    int errors = 0;

    clk_sel_ctrl #(
        .SETTLE_CYCLES (S),
        .DWELL_CYCLES  (D),
        .SYNC_STAGES   (SS),
        .CNT_W         (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_sel     (req_sel),
        .req_ready   (req_ready),
        .ok_a        (ok_a),
        .ok_b        (ok_b),
        .en          (en),
        .cur_sel     (cur_sel),
        .busy        (busy),
        .switch_done (switch_done),
        .err_reject  (err_reject),
        .switch_cnt  (switch_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk_b(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: switches tracked by their acceptance edge ----------
    int  e = 0;          // posedge index
    int  rel = -1;       // first edge after reset release
    int  m_acc = 0;      // edge at which the last real switch was accepted
    bit  m_have = 1'b0;
    bit  m_en = 1'b0, m_cur = 1'b0, m_busy = 1'b0, m_done = 1'b0, m_rej = 1'b0;
    int  m_cnt = 0;
    bit  hist_a[16];
    bit  hist_b[16];

    // Synchronized flag seen at edge ei is the raw input from SS edges earlier.
    function automatic bit oks(input bit sel, input int ei);
        int k;
        k = ei - SS;
        if (rel < 0 || k < rel) return 1'b0;
        return sel ? hist_a[k % 16] : hist_b[k % 16];
    endfunction

    task automatic model_step();
        bit idle;
        if (rst) begin
            m_en = 0; m_cur = 0; m_busy = 0; m_done = 0; m_rej = 0;
            m_cnt = 0; m_have = 0; rel = -1;
        end else begin
            if (rel < 0) rel = e;
            idle   = !m_busy;
            m_done = 0;
            m_rej  = 0;
            if (m_have && e == m_acc + S) begin
                m_done = 1;
                m_cur  = m_en;
                if (m_cnt < 255) m_cnt++;
            end
            if (idle && req_valid) begin
                if (req_sel == m_cur) m_done = 1;
                else if (!oks(req_sel, e)) m_rej = 1;
                else begin
                    m_have = 1;
                    m_acc  = e;
                    m_en   = req_sel;
                end
            end
            m_busy = m_have && (e >= m_acc) && (e < m_acc + S + D);
            hist_a[e % 16] = ok_a;
            hist_b[e % 16] = ok_b;
        end
        e++;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // ---------------- every-cycle compare ----------------------------------------
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                chk_b("cmp_rst_ready", req_ready, 1'b0);
                chk_b("cmp_rst_en", en, 1'b0);
                chk_i("cmp_rst_cnt", int'(switch_cnt), 0);
            end else begin
                chk_b("cmp_en", en, m_en);
                chk_b("cmp_cur_sel", cur_sel, m_cur);
                chk_b("cmp_busy", busy, m_busy);
                chk_b("cmp_req_ready", req_ready, !m_busy);
                chk_b("cmp_switch_done", switch_done, m_done);
                chk_b("cmp_err_reject", err_reject, m_rej);
                chk_i("cmp_switch_cnt", int'(switch_cnt), m_cnt);
            end
        end
    end

    // Hold a request until accepted; n counts negedges waited.
    task automatic do_req(input bit sel, output int n);
        req_sel   = sel;
        req_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 200);
        chk_b("req_accept_in_time", req_ready, 1'b1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 200);
        chk_b("idle_in_time", req_ready, 1'b1);
    endtask

    // ---------------- directed stimulus ------------------------------------------
    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk_b("reset_ready", req_ready, 1'b0);
        chk_b("reset_en", en, 1'b0);
        chk_b("reset_cur", cur_sel, 1'b0);
        chk_b("reset_busy", busy, 1'b0);
        chk_i("reset_cnt", int'(switch_cnt), 0);

        @(posedge clk);
        #1 rst = 1'b0;

        // Synchronizers still hold 0: first request is refused.
        do_req(1'b1, n);
        chk_i("early_wait", n, 1);
        @(negedge clk);
        chk_b("early_reject", err_reject, 1'b1);
        chk_b("early_en", en, 1'b0);

        repeat (4) @(posedge clk);
        #1;

        // Real switch to clka.
        do_req(1'b1, n);
        @(negedge clk);
        chk_b("sw1_en", en, 1'b1);
        chk_b("sw1_busy", busy, 1'b1);
        chk_b("sw1_ready", req_ready, 1'b0);
        chk_b("sw1_cur_early", cur_sel, 1'b0);
        repeat (16) @(negedge clk);
        chk_b("sw1_done", switch_done, 1'b1);
        chk_b("sw1_cur", cur_sel, 1'b1);
        chk_i("sw1_cnt", int'(switch_cnt), 1);

        // Request held through the dwell window.
        do_req(1'b0, n);
        chk_i("dwell_hold_wait", n, 64);
        @(negedge clk);
        chk_b("sw2_en", en, 1'b0);
        repeat (16) @(negedge clk);
        chk_b("sw2_done", switch_done, 1'b1);
        chk_b("sw2_cur", cur_sel, 1'b0);
        chk_i("sw2_cnt", int'(switch_cnt), 2);
        wait_idle();

        // Same-source request.
        do_req(1'b0, n);
        @(negedge clk);
        chk_b("same_done", switch_done, 1'b1);
        chk_b("same_busy", busy, 1'b0);
        chk_b("same_en", en, 1'b0);
        chk_i("same_cnt", int'(switch_cnt), 2);

        // Unhealthy target.
        ok_a = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        do_req(1'b1, n);
        @(negedge clk);
        chk_b("rej_pulse", err_reject, 1'b1);
        chk_b("rej_en", en, 1'b0);
        chk_b("rej_busy", busy, 1'b0);
        chk_i("rej_cnt", int'(switch_cnt), 2);

        // Reset in the middle of settle.
        ok_a = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        do_req(1'b1, n);
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk_b("midrst_en", en, 1'b0);
        chk_b("midrst_cur", cur_sel, 1'b0);
        chk_i("midrst_cnt", int'(switch_cnt), 0);
        chk_b("midrst_busy", busy, 1'b0);
        chk_b("midrst_ready", req_ready, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Health loss during settle does not abort the switch.
        do_req(1'b1, n);
        repeat (5) @(negedge clk);
        ok_a = 1'b0;
        repeat (12) @(negedge clk);
        chk_b("drop_done", switch_done, 1'b1);
        chk_b("drop_cur", cur_sel, 1'b1);
        chk_i("drop_cnt", int'(switch_cnt), 1);
        ok_a = 1'b1;
        wait_idle();

        // Saturation.
        for (int i = 0; i < 300; i++) begin
            do_req((i % 2) == 1, n);
        end
        wait_idle();
        chk_i("sat_cnt", int'(switch_cnt), 255);
        chk_i("sat_model_cnt", m_cnt, 255);
        chk_b("sat_cur", cur_sel, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_sel_ctrl.md
Name: clk_sel_ctrl

Overview:
Control stage directly upstream of the glitch-free two-source clock mux. Runs on an always-on control clock and accepts source-select requests over a valid/ready handshake. Checks that the target source is healthy, drives the mux `en` select, waits a settle interval, then enforces a minimum dwell time before the next switch. Reports completion, rejection and a switch count to the control plane.

Parameters:
SETTLE_CYCLES, 16, cycles from `en` change to switch_done; must be >=1; covers the mux's two-negedge handover.
DWELL_CYCLES, 64, minimum cycles after switch_done before the next request is accepted; 0 allowed.
SYNC_STAGES, 2, flop stages on each asynchronous ok input; must be >=2.
CNT_W, 8, width of the internal down-counter; must hold max(SETTLE_CYCLES, DWELL_CYCLES)-1.

Ports:
clk  input  1  control clock, always running
rst  input  1  asynchronous reset, active-high
req_valid  input  1  select request valid
req_sel  input  1  requested source: 1 = clka, 0 = clkb
req_ready  output  1  request accepted when req_valid && req_ready
ok_a  input  1  clka health flag, asynchronous
ok_b  input  1  clkb health flag, asynchronous
en  output  1  mux select, registered: 1 = clka, 0 = clkb
cur_sel  output  1  committed source; updates at switch_done
busy  output  1  high in SETTLE or DWELL
switch_done  output  1  one-cycle pulse at the end of settle, or on a same-source accept
err_reject  output  1  one-cycle pulse when a request is refused
switch_cnt  output  8  number of real switches; saturates at 255

Behaviour:
- Reset values: en=0, cur_sel=0, req_ready=0 during reset, busy=0, switch_done=0, err_reject=0, switch_cnt=0, sync flops=0, state=IDLE.
- Reset mid-operation: everything returns to reset values asynchronously. en=0 selects clkb, which is the mux's reset-safe default.
- ok_a and ok_b pass through SYNC_STAGES flops to give ok_a_s and ok_b_s. All decisions use only the synchronized values.
- Because the sync flops reset to 0, requests made in the first SYNC_STAGES cycles after reset are rejected.
- State IDLE (req_ready=1). On an accept at edge T:
  - If req_sel == cur_sel: switch_done pulse at T+1, no en change, switch_cnt unchanged, stay IDLE.
  - Else if the target's ok_s == 0: err_reject pulse at T+1, stay IDLE.
  - Else: en <= req_sel at T+1, go to SETTLE with counter = SETTLE_CYCLES-1.
- State SETTLE (req_ready=0, busy=1): counter decrements each cycle. At the edge where counter==0:
  - switch_done pulses, cur_sel <= en, and switch_cnt increments if below 255.
  - Go to DWELL with counter = DWELL_CYCLES-1, or go to IDLE if DWELL_CYCLES==0.
  - Result: switch_done is high in cycle T+1+SETTLE_CYCLES.
- State DWELL (req_ready=0, busy=1): counter decrements each cycle. Go to IDLE at the edge where counter==0. req_ready rises DWELL_CYCLES cycles after switch_done.
- A loss of ok on either source during SETTLE or DWELL is ignored. The switch completes, and the health check applies only at acceptance.
- req_valid held while req_ready=0 is not consumed. The requester holds req_valid and req_sel stable until accepted.
- At most one pulse (switch_done or err_reject) occurs per cycle. Pulses are registered outputs.

Optional Feature:
Macro CLK_SEL_FAILOVER_EN.
- Defined: adds output port fail_event (1-bit pulse). In IDLE, if the cur_sel source's ok_s==0 and the other source's ok_s==1, the block starts a switch to the other source exactly like an accepted request:
  - en flips at the next edge, then SETTLE and DWELL follow, and switch_cnt counts the switch.
  - fail_event pulses in the same cycle en flips.
  - Failover takes priority over a coincident req_valid: req_ready=0 that cycle and the request is not consumed.
  - If both sources are unhealthy, nothing happens.
- Undefined: no fail_event port and no autonomous switching. en changes only via accepted requests.

Test Plan:
- Reset release with ok_a=ok_b=1, wait 4 cycles, req_sel=1 accepted at cycle 10 -> en=1 from cycle 11, switch_done and cur_sel=1 at cycle 27, busy low and req_ready=1 at cycle 91, switch_cnt=1.
- ok_a=0 (synchronized), request req_sel=1 from IDLE with cur_sel=0 -> err_reject pulse one cycle after accept, en stays 0, switch_cnt=0.
- Request req_sel=0 while cur_sel=0 -> switch_done next cycle, en unchanged, busy never high, switch_cnt unchanged.
- Request during DWELL held for 30 cycles -> not accepted until req_ready rises, then a normal switch back to clkb. Assert rst mid-SETTLE -> en=0, cur_sel=0, switch_cnt=0 immediately.
- Toggle sources 300 times -> switch_cnt saturates at 255. Drop ok_a mid-SETTLE -> switch still completes with cur_sel=1.
- With CLK_SEL_FAILOVER_EN: cur_sel=1, drop ok_a with ok_b=1 -> after SYNC_STAGES+1 cycles en=0 and fail_event pulses, switch_done SETTLE_CYCLES later. With both ok flags low -> no action.
